alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Sits directly upstream of the 4-bit combinational ALU (ports a, b, op, result), which is instantiated alongside it, not inside it.
- Holds a small register file and accepts one command at a time over a valid/ready handshake. For each command it either loads an immediate value, or drives two register operands and an opcode into the ALU.
- Captures the ALU result, writes it back to a destination register, and presents it downstream with a zero flag over a second valid/ready handshake.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU width.
- NREG, 4, number of registers; power of two; index width RW = log2(NREG).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_kind  input  1  0 = ALU op, 1 = load immediate
- cmd_op  input  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_dst  input  RW  destination register index
- cmd_src_a  input  RW  operand A register index
- cmd_src_b  input  RW  operand B register index
- cmd_imm  input  DATA_W  immediate value (load only)
- alu_a  output  DATA_W  to ALU input a
- alu_b  output  DATA_W  to ALU input b
- alu_op  output  2  to ALU op
- alu_result  input  DATA_W  from ALU result
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  DATA_W  result value written to out_dst
- out_dst  output  RW  register that was written
- out_zero  output  1  out_data == 0

Behaviour:
- Reset (rst high at a clock edge):
  - state <= IDLE; all registers <= 0.
  - out_valid, out_data, out_dst, out_zero <= 0; alu_a, alu_b, alu_op <= 0.
  - cmd_ready is 0 in any cycle where rst is high.
  - Reset mid-operation abandons the command; no write-back and no out_valid.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch all cmd_* fields.
    - kind = 1: go to WB.
    - kind = 0: go to EXEC.
  - EXEC: cmd_ready = 0. alu_a = rf[src_a] and alu_b = rf[src_b] from the latched indices; alu_op = latched op. All three are held stable for the whole cycle. At the end of the cycle, capture alu_result and go to WB.
  - WB: one cycle, cmd_ready = 0.
    - Write rf[dst] <= captured value (the immediate for a load).
    - Load out_data, out_dst, out_zero; set out_valid <= 1; go to RESP.
  - RESP: out_valid = 1, cmd_ready = 0. Hold out_data, out_dst, out_zero stable until out_valid && out_ready at a clock edge, then clear out_valid and go to IDLE.
- Latency, command handshake in cycle N:
  - ALU op: ALU inputs valid in N+1, register write at the end of N+2, out_valid high from N+3.
  - Load: register write at the end of N+1, out_valid high from N+2.
  - Throughput is one command per 3 (load) or 4 (ALU) cycles when out_ready is held high.
- Next-command timing: the cycle after the output handshake is IDLE, so no same-cycle accept. There are no read-after-write hazards because the write-back always precedes the next EXEC.
- Arithmetic: performed entirely by the ALU, modulo 2^DATA_W. The sequencer adds no carry or overflow logic. out_zero is computed from the written value.
- src_a == src_b is legal (both ALU inputs get the same register). dst may equal a source; the source values are read in EXEC, before the write.
- When IDLE, alu_a, alu_b and alu_op hold their last values, which are don't-care to the ALU.
- out_ready while out_valid is low is ignored. cmd_valid outside IDLE is ignored; the command stays pending upstream.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11
  - KIND_ALU = 0, KIND_LOAD = 1
  - state encoding IDLE, EXEC, WB, RESP
- Sub-module alu_regfile: NREG x DATA_W; two combinational read ports, one synchronous write port; synchronous clear on rst.
- The ALU is not instantiated inside this block. A top-level wrapper connects the two blocks.

Test Plan:
- Reset with rf pre-written, then read back via ADD r0 = r1 + r2 -> out_data = 0, out_zero = 1; cmd_ready = 0 while rst is high.
- LOAD r1 = 3, LOAD r2 = 5, then ADD r0 = r1 + r2 -> out_data = 8, out_dst = 0, out_zero = 0; out_valid rises exactly 3 cycles after the ADD handshake.
- SUB r3 = r1 - r2 with r1 = 3, r2 = 5 -> out_data = 14 (wrap-around); then ADD r3 = r3 + r3 -> out_data = 12 (read before write).
- AND r0 = r1 & r2 with r1 = 4'b1010, r2 = 4'b0101 -> out_data = 0, out_zero = 1. OR r0 = r1 | r2 -> out_data = 15.
- Backpressure: hold out_ready = 0 for 5 cycles -> out_valid, out_data and out_dst stay stable, cmd_ready stays 0, and a queued cmd_valid is not accepted until the cycle after the output handshake.
- Assert rst while in EXEC of ADD r1 = r1 + r1 with r1 = 7 -> no out_valid, r1 reads 0 afterwards, state returns to IDLE.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// alu_seq_pkg: opcodes, command kinds and FSM states shared by the operand sequencer.
package alu_seq_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    localparam logic KIND_ALU  = 1'b0;
    localparam logic KIND_LOAD = 1'b1;
    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;
endpackage

// File: rtl/alu_operand_sequencer_regfile.sv
// alu_regfile: NREG x DATA_W register file, two async read ports, one sync write port, sync clear.
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREG = 4,
    localparam int RW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [RW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RW-1:0]     i_raddr_a,
    input  logic [RW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst)
            r_mem <= '{default: '0};
        else if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: feeds register operands to an external ALU and writes results back.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREG = 4,
    localparam int RW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_kind,
    input  logic [1:0]        cmd_op,
    input  logic [RW-1:0]     cmd_dst,
    input  logic [RW-1:0]     cmd_src_a,
    input  logic [RW-1:0]     cmd_src_b,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RW-1:0]     out_dst,
    output logic              out_zero
);
    state_t            r_state, w_next;
    logic [1:0]        r_op;
    logic [RW-1:0]     r_dst, r_src_a, r_src_b;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] w_rd_a, w_rd_b;
    logic              w_accept;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_next = (cmd_kind == KIND_LOAD) ? WB : EXEC;
            EXEC: w_next = WB;
            WB:   w_next = RESP;
            RESP: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_res carries the immediate for loads and is overwritten by the ALU result in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_dst     <= '0;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_res     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dst   <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= cmd_op;
                r_dst   <= cmd_dst;
                r_src_a <= cmd_src_a;
                r_src_b <= cmd_src_b;
                r_res   <= cmd_imm;
            end
            if (r_state == EXEC)
                r_res <= alu_result;
            if (r_state == WB) begin
                out_valid <= 1'b1;
                out_data  <= r_res;
                out_dst   <= r_dst;
                out_zero  <= (r_res == '0);
            end
            if (r_state == RESP && out_ready)
                out_valid <= 1'b0;
        end
    end

    alu_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (r_state == WB),
        .i_waddr   (r_dst),
        .i_wdata   (r_res),
        .i_raddr_a (r_src_a),
        .i_raddr_b (r_src_b),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // sources read from latched indices; stable through EXEC since rf only changes in WB
    assign alu_a  = w_rd_a;
    assign alu_b  = w_rd_b;
    assign alu_op = r_op;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: scoreboard bench with an external ALU and a register-level reference model.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] data;
        logic [1:0] dst;
        logic       zero;
        int         hs;
        int         lat;
    } exp_t;

    logic       clk = 0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_kind;
    logic [1:0] cmd_op, cmd_dst, cmd_src_a, cmd_src_b;
    logic [3:0] cmd_imm, alu_a, alu_b, alu_result, out_data;
    logic [1:0] alu_op, out_dst;
    logic       out_valid, out_ready, out_zero;
    logic       rand_rdy, fix_rdy, r_rnd;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [3:0] rf_m [4];
    exp_t       q[$];
    exp_t       e;
    logic       prev_v = 0;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        int r;
        case (op)
            OP_ADD:  r = int'(a) + int'(b);
            OP_SUB:  r = int'(a) - int'(b) + 16;
            OP_AND:  r = int'(a & b);
            default: r = int'(a | b);
        endcase
        return 4'(r % 16);
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);
    assign out_ready  = rand_rdy ? r_rnd : fix_rdy;

    alu_operand_sequencer #(.DATA_W(4), .NREG(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst(out_dst), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #1 r_rnd = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out_valid data=%0d dst=%0d", out_data, out_dst);
            end else begin
                e = q[0];
                if (!prev_v) begin
                    checks++;
                    if (cyc - e.hs != e.lat) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d", cyc - e.hs, e.lat);
                    end
                end
                checks++;
                if (out_data !== e.data || out_dst !== e.dst || out_zero !== e.zero) begin
                    errors++;
                    $display("FAIL out_fields got data=%0d dst=%0d zero=%0b exp data=%0d dst=%0d zero=%0b",
                             out_data, out_dst, out_zero, e.data, e.dst, e.zero);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_v = out_valid;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic send(input logic kind, input logic [1:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                        input bit expect_out, output int waited);
        bit   got = 0;
        exp_t x;
        @(posedge clk); #1;
        cmd_kind = kind; cmd_op = op; cmd_dst = dst;
        cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm; cmd_valid = 1;
        waited = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; break; end
            waited++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_accept_timeout waited=%0d", waited);
        end else if (expect_out) begin
            x.data = kind ? imm : alu_f(rf_m[sa], rf_m[sb], op);
            x.dst  = dst;
            x.zero = (x.data == 0);
            x.hs   = cyc;
            x.lat  = kind ? 2 : 3;
            rf_m[dst] = x.data;
            q.push_back(x);
        end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_left", q.size(), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) rf_m[i] = 0;
    endtask

    int w;

    initial begin
        rst = 1; cmd_valid = 0; cmd_kind = 0; cmd_op = 0; cmd_dst = 0;
        cmd_src_a = 0; cmd_src_b = 0; cmd_imm = 0; rand_rdy = 0; fix_rdy = 1;
        clear_model();
        @(negedge clk);
        chk("ready_in_reset", int'(cmd_ready), 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("idle_ready", int'(cmd_ready), 1);

        // pre-write registers then reset and read them back
        send(KIND_LOAD, 0, 2'd1, 0, 0, 4'd9, 1, w);
        send(KIND_LOAD, 0, 2'd2, 0, 0, 4'd6, 1, w);
        drain();
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("ready_in_reset2", int'(cmd_ready), 0);
        @(posedge clk); #1 rst = 0;
        clear_model();
        @(negedge clk);
        chk("post_reset_out_dst", int'(out_dst), 0);
        send(KIND_ALU, OP_ADD, 2'd0, 2'd1, 2'd2, 0, 1, w);
        drain();

        send(KIND_LOAD, 0, 2'd1, 0, 0, 4'd3, 1, w);
        send(KIND_LOAD, 0, 2'd2, 0, 0, 4'd5, 1, w);
        send(KIND_ALU, OP_ADD, 2'd0, 2'd1, 2'd2, 0, 1, w);
        send(KIND_ALU, OP_SUB, 2'd3, 2'd1, 2'd2, 0, 1, w);
        send(KIND_ALU, OP_ADD, 2'd3, 2'd3, 2'd3, 0, 1, w);
        send(KIND_LOAD, 0, 2'd1, 0, 0, 4'b1010, 1, w);
        send(KIND_LOAD, 0, 2'd2, 0, 0, 4'b0101, 1, w);
        send(KIND_ALU, OP_AND, 2'd0, 2'd1, 2'd2, 0, 1, w);
        send(KIND_ALU, OP_OR, 2'd0, 2'd1, 2'd2, 0, 1, w);
        drain();

        // backpressure with a queued command
        fix_rdy = 0;
        send(KIND_ALU, OP_ADD, 2'd2, 2'd1, 2'd1, 0, 1, w);
        cmd_kind = KIND_LOAD; cmd_dst = 2'd3; cmd_imm = 4'd9; cmd_valid = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
        end
        chk("bp_out_valid", int'(out_valid), 1);
        @(posedge clk); #1 fix_rdy = 1;
        @(negedge clk);
        chk("bp_ready_at_handshake", int'(cmd_ready), 0);
        send(KIND_LOAD, 0, 2'd3, 0, 0, 4'd9, 1, w);
        chk("bp_accept_next_cycle", w, 0);
        drain();

        // reset during EXEC abandons the command
        send(KIND_LOAD, 0, 2'd1, 0, 0, 4'd7, 1, w);
        drain();
        send(KIND_ALU, OP_ADD, 2'd1, 2'd1, 2'd1, 0, 0, w);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        clear_model();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", int'(out_valid), 0);
        end
        chk("abort_idle_ready", int'(cmd_ready), 1);
        send(KIND_ALU, OP_ADD, 2'd2, 2'd1, 2'd1, 0, 1, w);
        drain();

        rand_rdy = 1;
        for (int n = 0; n < 150; n++)
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1, w);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
